// File: rtl/huff_ahb_pkg.sv
// rtl/huff_ahb_pkg.sv - AHB-Lite encodings, writer states and codeword helpers for the Huffman writer
package huff_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_ADDR    = 3'd1,
        W_DATA    = 3'd2,
        W_TRAIL_A = 3'd3,
        W_TRAIL_D = 3'd4,
        W_DONE    = 3'd5,
        W_ERR     = 3'd6
    } wr_state_t;

    // Lengths above 16 are treated as a full 16-bit codeword.
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > 5'd16) ? 5'd16 : len;
    endfunction

endpackage

// File: rtl/code_packer.sv
// rtl/code_packer.sv - LSB-first codeword accumulator producing 32-bit words, with zero-padded flush
module code_packer
    import huff_ahb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic        i_flushing,
    input  logic        i_code_valid,
    input  logic [15:0] i_code_in,
    input  logic [4:0]  i_code_len,
    input  logic        i_word_ready,
    output logic        o_code_ready,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic        o_empty
);

    logic [63:0] r_acc;
    logic [6:0]  r_cnt;

    logic [4:0]  w_len;
    logic [16:0] w_mask;
    logic [63:0] w_ins;
    logic [63:0] w_acc_add;
    logic [6:0]  w_cnt_add;
    logic        w_accept;
    logic        w_push;

    assign w_len        = clamp_len(i_code_len);
    assign w_mask       = (17'd1 << w_len) - 17'd1;
    assign o_code_ready = i_enable & (r_cnt <= 7'd32);
    assign w_accept     = i_code_valid & o_code_ready;
    assign w_ins        = {47'd0, w_mask & {1'b0, i_code_in}} << r_cnt;
    assign w_acc_add    = w_accept ? (r_acc | w_ins) : r_acc;
    assign w_cnt_add    = w_accept ? (r_cnt + {2'b00, w_len}) : r_cnt;

    // Bits above cnt are always zero, so the low word doubles as the padded tail on flush.
    assign o_word       = r_acc[31:0];
    assign o_word_valid = (r_cnt >= 7'd32) | (i_flushing & (r_cnt != 7'd0));
    assign w_push       = o_word_valid & i_word_ready;
    assign o_empty      = (r_cnt == 7'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_acc <= 64'd0;
            r_cnt <= 7'd0;
        end else if (w_push) begin
            if (r_cnt >= 7'd32) begin
                r_acc <= w_acc_add >> 32;
                r_cnt <= w_cnt_add - 7'd32;
            end else begin
                r_acc <= 64'd0;
                r_cnt <= 7'd0;
            end
        end else begin
            r_acc <= w_acc_add;
            r_cnt <= w_cnt_add;
        end
    end

endmodule

// File: rtl/ahb_code_writer.sv
// rtl/ahb_code_writer.sv - AHB-Lite master writing packed Huffman words; AHB_WR_TRAILER_EN adds a bit-count trailer
module ahb_code_writer
    import huff_ahb_pkg::*;
#(
    parameter logic [31:0] OUT_BASE   = 32'd2001,
    parameter logic [31:0] LEN_ADDR   = 32'd2000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic        code_valid,
    input  logic [15:0] code_in,
    input  logic [4:0]  code_len,
    output logic        code_ready,
    input  logic        flush,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic [31:0] HADDR,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
`ifdef AHB_WR_TRAILER_EN
    localparam wr_state_t W_END = W_TRAIL_A;
`else
    localparam wr_state_t W_END = W_DONE;
`endif

    wr_state_t   r_state;
    wr_state_t   w_state_nxt;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic        r_flushing;
    logic [15:0] r_words;
    logic [31:0] r_fifo [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic [AW:0] w_count;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_push;
    logic        w_pop;
    logic        w_more;
    logic        w_err_hit;
    logic [31:0] w_word;
    logic        w_word_valid;
    logic        w_pk_empty;
    logic [31:0] w_trailer;

    code_packer u_packer (
        .i_clk        (HCLK),
        .i_rst        (HRESET),
        .i_clear      (start | w_err_hit),
        .i_enable     (r_busy & ~r_flushing),
        .i_flushing   (r_flushing),
        .i_code_valid (code_valid),
        .i_code_in    (code_in),
        .i_code_len   (code_len),
        .i_word_ready (~w_fifo_full),
        .o_code_ready (code_ready),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_empty      (w_pk_empty)
    );

    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_fifo_empty = (w_count == '0);
    assign w_fifo_full  = w_count[AW];
    assign w_push       = w_word_valid & ~w_fifo_full;
    assign w_pop        = (r_state == W_DATA) & HREADY & ~HRESP;
    // Chaining straight back to an address phase keeps zero-wait throughput at one word per two cycles.
    assign w_more       = (w_count > PTR_ONE) | w_push;

`ifdef AHB_WR_TRAILER_EN
    logic [31:0] r_bit_count;

    always_ff @(posedge HCLK) begin
        if (HRESET || start) begin
            r_bit_count <= 32'd0;
        end else if (code_valid && code_ready) begin
            r_bit_count <= r_bit_count + {27'd0, clamp_len(code_len)};
        end
    end

    assign w_trailer = r_bit_count;
`else
    assign w_trailer = 32'd0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_err_hit   = 1'b0;
        case (r_state)
            W_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = W_ADDR;
                end else if (r_flushing && w_pk_empty) begin
                    w_state_nxt = W_END;
                end
            end
            W_ADDR:    if (HREADY) w_state_nxt = W_DATA;
            W_DATA:    if (HREADY) w_state_nxt = w_more ? W_ADDR : W_IDLE;
            W_TRAIL_A: if (HREADY) w_state_nxt = W_TRAIL_D;
            W_TRAIL_D: if (HREADY) w_state_nxt = W_DONE;
            default: ;
        endcase
        if (HRESP && (r_state == W_ADDR || r_state == W_DATA ||
                      r_state == W_TRAIL_A || r_state == W_TRAIL_D)) begin
            w_err_hit   = 1'b1;
            w_state_nxt = W_ERR;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= W_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_flushing <= 1'b0;
            r_words    <= 16'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (start) begin
            r_state    <= W_IDLE;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_flushing <= 1'b0;
            r_words    <= 16'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush && r_busy) r_flushing <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_words  <= r_words + 16'd1;
            end
            if (w_err_hit) begin
                r_error    <= 1'b1;
                r_busy     <= 1'b0;
                r_flushing <= 1'b0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end
            if (w_state_nxt == W_DONE && r_state != W_DONE) begin
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
                r_flushing <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= w_word;
    end

    always_comb begin
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HADDR  = 32'd0;
        HWDATA = 32'd0;
        case (r_state)
            W_ADDR: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = OUT_BASE + {16'd0, r_words};
            end
            W_TRAIL_A: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = LEN_ADDR;
            end
            W_DATA:    HWDATA = r_fifo[r_rd_ptr[AW-1:0]];
            W_TRAIL_D: HWDATA = w_trailer;
            default: ;
        endcase
    end

    assign HSIZE         = HSIZE_WORD;
    assign HBURST        = HBURST_SINGLE;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words;

endmodule

// File: tb/tb_ahb_code_writer.sv
// tb/tb_ahb_code_writer.sv - self-checking bench for ahb_code_writer against a bit-queue reference model
module tb_ahb_code_writer;

    logic        HCLK = 1'b0;
    logic        HRESET, start, code_valid, flush, HREADY, HRESP;
    logic [15:0] code_in;
    logic [4:0]  code_len;
    logic        code_ready, HWRITE, busy, done, error;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [15:0] words_written;

    ahb_code_writer dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .code_valid(code_valid),
        .code_in(code_in), .code_len(code_len), .code_ready(code_ready), .flush(flush),
        .HREADY(HREADY), .HRESP(HRESP), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .busy(busy), .done(done),
        .error(error), .words_written(words_written)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Bus monitor: logs completed writes and counts HWDATA changes during wait states.
    logic [31:0] log_addr [512];
    logic [31:0] log_data [512];
    int          log_n      = 0;
    int          mon_naddr  = 0;
    int          stab_err   = 0;
    logic        mon_dphase = 1'b0;
    logic        stall_seen = 1'b0;
    logic [31:0] mon_addr;
    logic [31:0] stall_data;

    always @(negedge HCLK) begin
        if (HRESET) begin
            mon_dphase = 1'b0;
            stall_seen = 1'b0;
        end else begin
            if (mon_dphase) begin
                if (stall_seen && HWDATA !== stall_data) stab_err++;
                if (HRESP) begin
                    mon_dphase = 1'b0;
                    stall_seen = 1'b0;
                end else if (HREADY) begin
                    if (log_n < 512) begin
                        log_addr[log_n] = mon_addr;
                        log_data[log_n] = HWDATA;
                        log_n++;
                    end
                    mon_dphase = 1'b0;
                    stall_seen = 1'b0;
                end else begin
                    stall_seen = 1'b1;
                    stall_data = HWDATA;
                end
            end
            if (HTRANS == 2'b10 && HWRITE && HREADY && !HRESP) begin
                mon_dphase = 1'b1;
                mon_addr   = HADDR;
                mon_naddr++;
            end
        end
    end

    bit mq[$];
    int rand_ready = 0;
    int stall_left = 0;
    int n_backoff  = 0;

    task automatic tick();
        @(posedge HCLK);
        #1;
        if (stall_left > 0 && mon_dphase) begin
            HREADY = 1'b0;
            stall_left--;
        end else if (rand_ready != 0) begin
            HREADY = ($urandom_range(0, 2) != 0);
        end else begin
            HREADY = 1'b1;
        end
    endtask

    task automatic model_add(input logic [15:0] d, input logic [4:0] l);
        int n;
        n = (l > 5'd16) ? 16 : int'(l);
        for (int i = 0; i < n; i++) mq.push_back(d[i]);
    endtask

    task automatic send_code(input logic [15:0] d, input logic [4:0] l);
        logic acc;
        int   cyc;
        cyc        = 0;
        code_valid = 1'b1;
        code_in    = d;
        code_len   = l;
        do begin
            @(negedge HCLK);
            acc = code_ready;
            if (!acc) n_backoff++;
            tick();
            cyc++;
        end while (!acc && cyc < 500);
        code_valid = 1'b0;
        if (acc) begin
            model_add(d, l);
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout got code_ready=0 exp 1");
        end
    endtask

    task automatic start_session();
        mq.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        @(negedge HCLK);
        while (!done && cyc < 3000) begin
            tick();
            @(negedge HCLK);
            cyc++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s done_timeout got 0 exp 1", name);
        end
        tick();
    endtask

    task automatic check_session(input int base, input string name);
        int          nw, ne;
        logic [31:0] exp_w, exp_a;
        nw = (mq.size() + 31) / 32;
        ne = nw;
`ifdef AHB_WR_TRAILER_EN
        ne = nw + 1;
`endif
        n_cmp++;
        if (log_n - base != ne) begin
            n_fail++;
            $display("FAIL %s write_count got %0d exp %0d", name, log_n - base, ne);
        end
        for (int k = 0; k < nw && base + k < log_n; k++) begin
            exp_w = 32'd0;
            for (int b = 0; b < 32; b++)
                if (32 * k + b < mq.size()) exp_w[b] = mq[32 * k + b];
            exp_a = 32'd2001 + 32'(k);
            n_cmp++;
            if (log_addr[base + k] !== exp_a || log_data[base + k] !== exp_w) begin
                n_fail++;
                $display("FAIL %s word%0d got %0d:%h exp %0d:%h", name, k,
                         log_addr[base + k], log_data[base + k], exp_a, exp_w);
            end
        end
`ifdef AHB_WR_TRAILER_EN
        if (base + nw < log_n) begin
            n_cmp++;
            if (log_addr[base + nw] !== 32'd2000 || log_data[base + nw] !== 32'(mq.size())) begin
                n_fail++;
                $display("FAIL %s trailer got %0d:%0d exp 2000:%0d", name,
                         log_addr[base + nw], log_data[base + nw], mq.size());
            end
        end
`endif
        n_cmp++;
        if (words_written !== 16'(nw) || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s final_status got ww=%0d done=%b busy=%b exp ww=%0d done=1 busy=0",
                     name, words_written, done, busy, nw);
        end
    endtask

    task automatic test_reset();
        logic [72:0] bus;
        logic [19:0] st;
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
        @(negedge HCLK);
        bus = {HADDR, HWDATA, HWRITE, HTRANS, HSIZE, HBURST};
        st  = {code_ready, busy, done, error, words_written};
        n_cmp++;
        if (bus !== {32'd0, 32'd0, 1'b0, 2'b00, 3'b010, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_bus got %h exp %h", bus, {32'd0, 32'd0, 1'b0, 2'b00, 3'b010, 3'b000});
        end
        n_cmp++;
        if (st !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_status got %h exp 0", st);
        end
        tick();
    endtask

    task automatic test_two_codes();
        int base;
        base = log_n;
        start_session();
        send_code(16'hABCD, 5'd16);
        send_code(16'h1234, 5'd16);
        @(negedge HCLK);
        tick();
        @(negedge HCLK);
        n_cmp++;
        if (HTRANS !== 2'b00) begin
            n_fail++;
            $display("FAIL early_addr_phase got HTRANS=%b exp 00", HTRANS);
        end
        tick();
        @(negedge HCLK);
        n_cmp++;
        if (HTRANS !== 2'b10 || HWRITE !== 1'b1 || HADDR !== 32'd2001) begin
            n_fail++;
            $display("FAIL addr_phase got %b/%b/%0d exp 10/1/2001", HTRANS, HWRITE, HADDR);
        end
        tick();
        @(negedge HCLK);
        n_cmp++;
        if (HWDATA !== 32'h1234ABCD || HTRANS !== 2'b00) begin
            n_fail++;
            $display("FAIL data_phase got %h/%b exp 1234abcd/00", HWDATA, HTRANS);
        end
        tick();
        @(negedge HCLK);
        n_cmp++;
        if (words_written !== 16'd1 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL after_write got ww=%0d busy=%b done=%b exp 1/1/0", words_written, busy, done);
        end
        tick();
        do_flush();
        wait_done("two_codes");
        check_session(base, "two_codes");
    endtask

    task automatic test_flush_partial();
        int base;
        base = log_n;
        start_session();
        send_code(16'h0005, 5'd3);
        do_flush();
        wait_done("flush_partial");
        check_session(base, "flush_partial");
    endtask

    task automatic test_random(input int iter);
        int base;
        for (int s = 0; s < iter; s++) begin
            base       = log_n;
            rand_ready = s % 2;
            start_session();
            for (int c = 0; c < 10 + int'($urandom_range(0, 20)); c++) begin
                send_code(16'($urandom), 5'($urandom_range(0, 20)));
                if ($urandom_range(0, 3) == 0) tick();
            end
            do_flush();
            wait_done("random");
            rand_ready = 0;
            check_session(base, "random");
        end
    endtask

    task automatic test_backpressure();
        int base, se;
        base       = log_n;
        se         = stab_err;
        n_backoff  = 0;
        start_session();
        stall_left = 12;
        for (int c = 0; c < 24; c++) send_code(16'($urandom), 5'd16);
        do_flush();
        wait_done("backpressure");
        n_cmp++;
        if (n_backoff == 0) begin
            n_fail++;
            $display("FAIL backpressure_ready got no stall exp code_ready low");
        end
        n_cmp++;
        if (stab_err != se) begin
            n_fail++;
            $display("FAIL hwdata_stable got %0d changes exp 0", stab_err - se);
        end
        check_session(base, "backpressure");
    endtask

    task automatic test_error();
        int   base, cyc, na;
        logic rdy_seen;
        start_session();
        send_code(16'h1111, 5'd16);
        send_code(16'h2222, 5'd16);
        cyc = 0;
        while (!mon_dphase && cyc < 100) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (!mon_dphase) begin
            n_fail++;
            $display("FAIL err_dphase_timeout got 0 exp 1");
        end
        HRESP  = 1'b1;
        HREADY = 1'b0;
        @(posedge HCLK);
        #1;
        HRESP  = 1'b0;
        HREADY = 1'b1;
        @(negedge HCLK);
        n_cmp++;
        if (error !== 1'b1 || HTRANS !== 2'b00 || code_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_state got err=%b htrans=%b rdy=%b busy=%b exp 1/00/0/0",
                     error, HTRANS, code_ready, busy);
        end
        tick();
        na         = mon_naddr;
        rdy_seen   = 1'b0;
        code_valid = 1'b1;
        code_len   = 5'd16;
        for (int i = 0; i < 8; i++) begin
            @(negedge HCLK);
            if (code_ready) rdy_seen = 1'b1;
            tick();
        end
        code_valid = 1'b0;
        n_cmp++;
        if (rdy_seen || mon_naddr != na || error !== 1'b1) begin
            n_fail++;
            $display("FAIL err_quiet got rdy=%b xfers=%0d err=%b exp 0/0/1", rdy_seen, mon_naddr - na, error);
        end
        base = log_n;
        start_session();
        @(negedge HCLK);
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_restart got err=%b busy=%b exp 0/1", error, busy);
        end
        tick();
        send_code(16'hBEEF, 5'd16);
        send_code(16'hCAFE, 5'd16);
        do_flush();
        wait_done("err_restart");
        check_session(base, "err_restart");
    endtask

    task automatic test_reset_mid();
        int          base;
        logic [72:0] bus;
        start_session();
        for (int c = 0; c < 5; c++) send_code(16'($urandom), 5'd16);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        @(negedge HCLK);
        bus = {HADDR, HWDATA, HWRITE, HTRANS, HSIZE, HBURST};
        n_cmp++;
        if (bus !== {32'd0, 32'd0, 1'b0, 2'b00, 3'b010, 3'b000} ||
            {code_ready, busy, done, error, words_written} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_mid got bus=%h ww=%0d busy=%b exp idle", bus, words_written, busy);
        end
        tick();
        base = log_n;
        start_session();
        send_code(16'hFFFF, 5'd16);
        send_code(16'hFFFF, 5'd16);
        do_flush();
        wait_done("reset_mid");
        check_session(base, "reset_mid");
    endtask

    task automatic test_start_flush_same();
        int base;
        base  = log_n;
        mq.delete();
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        @(negedge HCLK);
        n_cmp++;
        if (busy !== 1'b1 || code_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_wins got busy=%b rdy=%b done=%b exp 1/1/0", busy, code_ready, done);
        end
        tick();
        send_code(16'h00FF, 5'd8);
        send_code(16'h0155, 5'd0);
        send_code(16'hF0F0, 5'd31);
        do_flush();
        wait_done("start_flush");
        check_session(base, "start_flush");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET     = 1'b1;
        start      = 1'b0;
        flush      = 1'b0;
        code_valid = 1'b0;
        code_in    = 16'd0;
        code_len   = 5'd0;
        HREADY     = 1'b1;
        HRESP      = 1'b0;
        test_reset();
        test_two_codes();
        test_flush_partial();
        test_random(6);
        test_backpressure();
        test_error();
        test_reset_mid();
        test_start_flush_same();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
